// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score_keeper slice.
package score_keeper_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [15:0] SCORE_MAX     = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    CMP   = 2'd2,
    HS_WR = 2'd3
  } state_t;

endpackage

// File: rtl/score_keeper_bcd_digit_inc.sv
// Combinational single BCD digit increment with carry in/out.
module bcd_digit_inc
  import score_keeper_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] digit_c,
  output logic               carry_c
);

  always_comb begin
    digit_c = digit_in;
    carry_c = 1'b0;
    if (carry_in) begin
      if (digit_in >= BCD_MAX_DIGIT) begin
        digit_c = '0;
        carry_c = 1'b1;
      end else begin
        digit_c = digit_in + DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Packed-BCD score/highscore sequencer with buffered point events.
// Define SCORE_SAT_EN to saturate the score at 9999 instead of wrapping to 0000.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int unsigned PEND_W = 3,
  parameter int unsigned NDIG   = 4
) (
  input  logic                      ClkPort,
  input  logic                      Reset,
  input  logic                      point_req,
  input  logic                      clear,
  output logic [NDIG*DIGIT_W-1:0]   score,
  output logic [NDIG*DIGIT_W-1:0]   highscore,
  output logic                      new_high,
  output logic                      busy,
  output logic                      dropped
);

  localparam int unsigned SCORE_W = NDIG * DIGIT_W;
  localparam int unsigned IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [SCORE_W-1:0]  score_d, highscore_d;
  logic                new_high_d, dropped_d, busy_d;
  logic                launch;
  logic [DIGIT_W-1:0]  cur_digit, inc_digit;
  logic                inc_carry;

  assign launch    = (state_q == IDLE) && (pend_q != '0);
  assign cur_digit = score[idx_q*DIGIT_W +: DIGIT_W];

  bcd_digit_inc u_inc (
    .digit_in (cur_digit),
    .carry_in (carry_q),
    .digit_c  (inc_digit),
    .carry_c  (inc_carry)
  );

  // Registers: FSM state plus all datapath and output flops.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      pend_q    <= '0;
      score     <= '0;
      highscore <= '0;
      new_high  <= 1'b0;
      dropped   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      pend_q    <= pend_d;
      score     <= score_d;
      highscore <= highscore_d;
      new_high  <= new_high_d;
      dropped   <= dropped_d;
      busy      <= busy_d;
    end
  end

  // Next-state, pending bookkeeping and digit ripple.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    pend_d      = pend_q;
    score_d     = score;
    highscore_d = highscore;
    new_high_d  = 1'b0;
    dropped_d   = dropped;

    if (point_req && !launch) begin
      if (pend_q == PEND_MAX) dropped_d = 1'b1;
      else                    pend_d    = pend_q + PEND_W'(1);
    end else if (launch && !point_req) begin
      pend_d = pend_q - PEND_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (launch) begin
          idx_d   = '0;
          carry_d = 1'b1;
          state_d = ADD;
`ifdef SCORE_SAT_EN
          if (score == SCORE_MAX) state_d = CMP;
`endif
        end
      end
      ADD: begin
        score_d[idx_q*DIGIT_W +: DIGIT_W] = inc_digit;
        if (inc_carry && (idx_q != IDX_W'(NDIG - 1))) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          carry_d = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        // BCD ordering matches numeric ordering, so a plain unsigned compare works.
        if (score > highscore) begin
          state_d    = HS_WR;
          new_high_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HS_WR: begin
        highscore_d = score;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d     = IDLE;
      idx_d       = '0;
      carry_d     = 1'b0;
      pend_d      = '0;
      score_d     = '0;
      highscore_d = highscore;
      new_high_d  = 1'b0;
      dropped_d   = 1'b0;
    end

    busy_d = (state_d != IDLE) || (pend_d != '0);
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus pushes expectations, monitor checks on busy fall.
module tb_score_keeper;

  logic        ClkPort = 1'b0;
  logic        Reset;
  logic        point_req;
  logic        clear;
  logic [15:0] score;
  logic [15:0] highscore;
  logic        new_high;
  logic        busy;
  logic        dropped;

  typedef struct {
    logic [15:0] score;
    logic [15:0] hs;
    int          nh;
    logic        dropped;
  } exp_t;

  exp_t        exp_q[$];
  int          passed = 0;
  int          total  = 0;
  int          nh_cnt = 0;
  logic        prev_busy = 1'b0;
  logic [15:0] m_score, m_hs;
  int          m_nh;
  logic        m_dropped;

  always #5 ClkPort = ~ClkPort;

  score_keeper #(.PEND_W(3), .NDIG(4)) dut (
    .ClkPort   (ClkPort),
    .Reset     (Reset),
    .point_req (point_req),
    .clear     (clear),
    .score     (score),
    .highscore (highscore),
    .new_high  (new_high),
    .busy      (busy),
    .dropped   (dropped)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    int v;
    v = int'(s[15:12]) * 1000 + int'(s[11:8]) * 100 + int'(s[7:4]) * 10 + int'(s[3:0]) + 1;
`ifdef SCORE_SAT_EN
    if (v > 9999) v = 9999;
`else
    if (v > 9999) v = 0;
`endif
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic expect_points(input int n);
    for (int i = 0; i < n; i++) begin
      m_score = bcd_inc(m_score);
      if (m_score > m_hs) begin
        m_hs = m_score;
        m_nh++;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.score   = m_score;
    e.hs      = m_hs;
    e.nh      = m_nh;
    e.dropped = m_dropped;
    exp_q.push_back(e);
    m_nh = 0;
  endtask

  // Monitor: every completed sequence (busy falling) is checked against the queue.
  always @(negedge ClkPort) begin
    exp_t e;
    if (new_high === 1'b1) nh_cnt++;
    if (prev_busy === 1'b1 && busy === 1'b0) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: busy fell with 0 queued expectations, needed 1");
      end else begin
        e = exp_q.pop_front();
        check("sb_score", 32'(score), 32'(e.score));
        check("sb_highscore", 32'(highscore), 32'(e.hs));
        check("sb_new_high_count", 32'(nh_cnt), 32'(e.nh));
        check("sb_dropped", 32'(dropped), 32'(e.dropped));
      end
      nh_cnt = 0;
    end
    prev_busy = busy;
  end

  task automatic do_reset();
    Reset     = 1'b1;
    point_req = 1'b0;
    clear     = 1'b0;
    repeat (2) @(posedge ClkPort);
    #1 Reset  = 1'b0;
    m_score   = '0;
    m_hs      = '0;
    m_nh      = 0;
    m_dropped = 1'b0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      point_req = 1'b1;
      @(posedge ClkPort);
      #1;
    end
    point_req = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge ClkPort);
    #1 clear = 1'b0;
    m_score   = '0;
    m_dropped = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    do begin
      @(negedge ClkPort);
      c++;
    end while (busy !== 1'b0 && c < budget);
    if (busy !== 1'b0) begin
      total++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, c);
    end
    @(posedge ClkPort);
    #1;
  endtask

  task automatic climb(input int n);
    int left = n;
    int k;
    while (left > 0) begin
      k = (left > 6) ? 6 : left;
      pulses(k);
      expect_points(k);
      push_expect();
      wait_idle(k * 12 + 40, "climb");
      left -= k;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; point_req = 1'b0; clear = 1'b0;
    do_reset();
    check("rst_score", 32'(score), 32'h0);
    check("rst_highscore", 32'(highscore), 32'h0);
    check("rst_new_high", 32'(new_high), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dropped", 32'(dropped), 32'h0);

    // Back-to-back burst overruns the 3-bit pending counter: two of twelve points are lost.
    pulses(12);
    expect_points(10);
    m_dropped = 1'b1;
    push_expect();
    wait_idle(300, "burst");
    pulse_clear();
    check("clr_burst_score", 32'(score), 32'h0);
    check("clr_burst_highscore", 32'(highscore), 32'h0010);
    check("clr_burst_dropped", 32'(dropped), 32'h0);

    // Single point latency.
    do_reset();
    pulses(1);
    expect_points(1);
    push_expect();
    check("lat_busy_e1", 32'(busy), 32'h1);
    @(posedge ClkPort); #1 check("lat_score_e2", 32'(score), 32'h0);
    @(posedge ClkPort); #1 check("lat_score_e3", 32'(score), 32'h0001);
    @(posedge ClkPort); #1 check("lat_new_high_e4", 32'(new_high), 32'h1);
    check("lat_hs_e4", 32'(highscore), 32'h0);
    @(posedge ClkPort); #1 check("lat_hs_e5", 32'(highscore), 32'h0001);
    check("lat_new_high_e5", 32'(new_high), 32'h0);
    wait_idle(20, "single");

    // 0x0099 -> 0x0100 ripples through three digits.
    climb(98);
    check("pre_99", 32'(score), 32'h0099);
    pulses(1);
    expect_points(1);
    push_expect();
    @(posedge ClkPort); #1 check("rip_e2", 32'(score), 32'h0099);
    @(posedge ClkPort); #1 check("rip_e3", 32'(score), 32'h0090);
    @(posedge ClkPort); #1 check("rip_e4", 32'(score), 32'h0000);
    @(posedge ClkPort); #1 check("rip_e5", 32'(score), 32'h0100);
    @(posedge ClkPort); #1 check("rip_new_high_e6", 32'(new_high), 32'h1);
    @(posedge ClkPort); #1 check("rip_hs_e7", 32'(highscore), 32'h0100);
    wait_idle(20, "ripple");

    // Clear keeps highscore; later smaller scores never pulse new_high.
    do_reset();
    climb(42);
    pulse_clear();
    check("clr_score", 32'(score), 32'h0);
    check("clr_highscore", 32'(highscore), 32'h0042);
    for (int i = 0; i < 3; i++) begin
      pulses(1);
      expect_points(1);
      push_expect();
      wait_idle(20, "post_clear");
    end
    check("post_clear_score", 32'(score), 32'h0003);

    // Top of range: saturate or wrap depending on build.
    do_reset();
    climb(9999);
    check("top_score", 32'(score), 32'h9999);
    pulses(1);
    expect_points(1);
    push_expect();
    wait_idle(20, "top");
`ifdef SCORE_SAT_EN
    check("top_next_score", 32'(score), 32'h9999);
`else
    check("top_next_score", 32'(score), 32'h0000);
`endif
    check("top_next_hs", 32'(highscore), 32'h9999);

    // Asynchronous reset mid-ADD.
    pulse_clear();
    pulses(1);
    @(posedge ClkPort); #1 check("abort_busy", 32'(busy), 32'h1);
    m_score = '0; m_hs = '0; m_nh = 0; m_dropped = 1'b0;
    push_expect();
    #2 Reset = 1'b1;
    #1;
    check("async_rst_score", 32'(score), 32'h0);
    check("async_rst_hs", 32'(highscore), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_new_high", 32'(new_high), 32'h0);
    @(posedge ClkPort); #1 Reset = 1'b0;

    // clear beats a simultaneous point_req.
    climb(2);
    point_req = 1'b1;
    clear     = 1'b1;
    @(posedge ClkPort);
    #1 point_req = 1'b0;
    clear = 1'b0;
    check("clr_pt_score", 32'(score), 32'h0);
    check("clr_pt_busy", 32'(busy), 32'h0);
    check("clr_pt_hs", 32'(highscore), 32'h0002);
    repeat (4) @(posedge ClkPort);
    #1 check("clr_pt_score_later", 32'(score), 32'h0);
    check("clr_pt_busy_later", 32'(busy), 32'h0);

    repeat (2) @(posedge ClkPort);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
